twp_master: RTL and testbench

- Two-Wire Protocol host that sits directly upstream of the TWP slave port of the register block.
- Accepts single read/write commands from a local requester over a valid/ready handshake.
- Serializes each command onto SDA, one bit per clk. For reads, it releases SDA, detects the slave's response start bit and captures 16 data bits.
- Returns one response per command: read data plus an error flag.

---
 rtl/twp_master.sv | 229 ++++++++++++++++++++++
 tb/tb_twp_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twp_master.sv
// Two-Wire Protocol host: serializes single read/write commands onto SDA one bit
// per clk and returns one response (read data + timeout flag) per command.
module twp_master #(
    parameter int RD_TIMEOUT = 16,
    parameter int IDLE_GAP   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        SCL,
    inout  wire         SDA
);

    localparam logic [7:0] LP_TIMEOUT = 8'(RD_TIMEOUT);
    localparam logic [7:0] LP_GAP     = 8'(IDLE_GAP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_CMD   = 3'd2,
        S_ADDR  = 3'd3,
        S_WDATA = 3'd4,
        S_TURN  = 3'd5,
        S_RDATA = 3'd6,
        S_GAP   = 3'd7
    } state_t;

    state_t      r_state,     w_state_nxt;
    logic        r_write,     w_write_nxt;
    logic [7:0]  r_addr,      w_addr_nxt;
    logic [15:0] r_wdata,     w_wdata_nxt;
    logic [3:0]  r_bit_cnt,   w_bit_cnt_nxt;
    logic [7:0]  r_cnt,       w_cnt_nxt;
    logic [15:0] r_shift,     w_shift_nxt;
    logic        r_gap_rd,    w_gap_rd_nxt;
    logic        r_sda_out,   w_sda_out_nxt;
    logic        r_sda_oe,    w_sda_oe_nxt;
    logic        r_rsp_valid, w_rsp_valid_nxt;
    logic [15:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic        r_rsp_err,   w_rsp_err_nxt;
    logic        r_cmd_ready;
    logic        r_busy;
    logic        r_scl;
    logic        w_sda_in;

    // SDA drive is registered together with the state, so each bit occupies exactly its state's cycle.
    assign SDA       = r_sda_oe ? r_sda_out : 1'bz;
    assign w_sda_in  = SDA;
    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign SCL       = r_scl;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_addr      <= 8'h00;
            r_wdata     <= 16'h0000;
            r_bit_cnt   <= 4'd0;
            r_cnt       <= 8'd0;
            r_shift     <= 16'h0000;
            r_gap_rd    <= 1'b0;
            r_sda_out   <= 1'b1;
            r_sda_oe    <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 16'h0000;
            r_rsp_err   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_scl       <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_write     <= w_write_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_gap_rd    <= w_gap_rd_nxt;
            r_sda_out   <= w_sda_out_nxt;
            r_sda_oe    <= w_sda_oe_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_scl       <= (w_state_nxt == S_IDLE);
        end
    end

    // Next-state, shift/counter updates and the SDA value for the next cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_write_nxt     = r_write;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_gap_rd_nxt    = r_gap_rd;
        w_sda_out_nxt   = r_sda_out;
        w_sda_oe_nxt    = r_sda_oe;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;

        case (r_state)
            S_IDLE: begin
                w_sda_out_nxt = 1'b1;
                w_sda_oe_nxt  = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_state_nxt   = S_START;
                    w_write_nxt   = cmd_write;
                    w_addr_nxt    = cmd_addr;
                    w_wdata_nxt   = cmd_wdata;
                    w_bit_cnt_nxt = 4'd0;
                    w_cnt_nxt     = 8'd0;
                    w_shift_nxt   = 16'h0000;
                    w_sda_out_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                w_state_nxt   = S_CMD;
                w_sda_out_nxt = r_write;
            end
            S_CMD: begin
                w_state_nxt   = S_ADDR;
                w_bit_cnt_nxt = 4'd0;
                w_sda_out_nxt = r_addr[0];
            end
            S_ADDR: begin
                if (r_bit_cnt == 4'd7) begin
                    w_bit_cnt_nxt = 4'd0;
                    if (r_write) begin
                        w_state_nxt   = S_WDATA;
                        w_sda_out_nxt = r_wdata[0];
                    end else begin
                        w_state_nxt  = S_TURN;
                        w_sda_oe_nxt = 1'b0;
                        w_cnt_nxt    = 8'd1;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    w_addr_nxt    = {1'b0, r_addr[7:1]};
                    w_sda_out_nxt = r_addr[1];
                end
            end
            S_WDATA: begin
                if (r_bit_cnt == 4'd15) begin
                    w_state_nxt     = S_GAP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = 16'h0000;
                    w_cnt_nxt       = 8'd1;
                    w_gap_rd_nxt    = 1'b0;
                    w_sda_out_nxt   = 1'b1;
                    w_sda_oe_nxt    = 1'b1;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    w_wdata_nxt   = {1'b0, r_wdata[15:1]};
                    w_sda_out_nxt = r_wdata[1];
                end
            end
            S_TURN: begin
                w_sda_oe_nxt = 1'b0;
                // A start bit on the last permitted cycle still wins over the timeout.
                if (w_sda_in == 1'b0) begin
                    w_state_nxt   = S_RDATA;
                    w_bit_cnt_nxt = 4'd0;
                end else if (r_cnt >= LP_TIMEOUT) begin
                    w_state_nxt     = S_GAP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = 16'h0000;
                    w_cnt_nxt       = 8'd1;
                    w_gap_rd_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_RDATA: begin
                w_sda_oe_nxt = 1'b0;
                w_shift_nxt  = {w_sda_in, r_shift[15:1]};
                if (r_bit_cnt == 4'd15) begin
                    w_state_nxt     = S_GAP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = w_shift_nxt;
                    w_cnt_nxt       = 8'd1;
                    w_gap_rd_nxt    = 1'b1;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                end
            end
            S_GAP: begin
                // After a read the bus stays released so a late slave drive cannot contend.
                if (r_cnt >= LP_GAP) begin
                    w_state_nxt   = S_IDLE;
                    w_sda_out_nxt = 1'b1;
                    w_sda_oe_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt     = r_cnt + 8'd1;
                    w_sda_out_nxt = 1'b1;
                    w_sda_oe_nxt  = !r_gap_rd;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_sda_out_nxt = 1'b1;
                w_sda_oe_nxt  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_twp_master.sv
// Self-checking bench for twp_master: table of single transactions against a
// behavioural TWP slave, plus back-to-back and mid-frame reset sequences.
module tb_twp_master;

    localparam int RD_TIMEOUT = 16;
    localparam int IDLE_GAP   = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = 8'h00;
    logic [15:0] cmd_wdata = 16'h0000;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        SCL;
    wire         SDA;

    pullup (SDA);

    twp_master #(.RD_TIMEOUT(RD_TIMEOUT), .IDLE_GAP(IDLE_GAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .SCL(SCL), .SDA(SDA)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [15:0] last_rd = 16'h0000;
    logic        last_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural TWP slave ----------------
    typedef enum logic [1:0] {SL_IDLE, SL_RX, SL_RD, SL_WAIT} sl_t;
    sl_t         sl_st = SL_IDLE;
    int          sl_idx = 0;
    int          sl_ph = 0;
    logic        sl_wr = 1'b0;
    logic [7:0]  sl_addr = 8'h00;
    logic [7:0]  sl_last_addr = 8'h00;
    logic [15:0] sl_wd = 16'h0000;
    logic [15:0] sl_mem [0:255];
    int          sl_turn = 0;
    bit          sl_silent = 1'b0;
    logic [15:0] sl_rd_data = 16'h0000;
    logic        sl_oe;
    logic        sl_val;

    always @(posedge clk) begin
        if (SCL) begin
            sl_st <= SL_IDLE;
        end else begin
            case (sl_st)
                SL_IDLE: begin
                    sl_st  <= SL_RX;
                    sl_idx <= 1;
                end
                SL_RX: begin
                    if (sl_idx == 1) sl_wr <= SDA;
                    else if (sl_idx <= 9) sl_addr[sl_idx-2] <= SDA;
                    else sl_wd[sl_idx-10] <= SDA;
                    sl_idx <= sl_idx + 1;
                    if (sl_idx == 9) sl_last_addr <= {SDA, sl_addr[6:0]};
                    if (sl_idx == 9 && !sl_wr) begin
                        sl_st <= SL_RD;
                        sl_ph <= 1;
                    end else if (sl_idx == 25) begin
                        sl_mem[sl_addr] <= {SDA, sl_wd[14:0]};
                        sl_st <= SL_WAIT;
                    end
                end
                SL_RD: begin
                    sl_ph <= sl_ph + 1;
                    if (sl_ph > sl_turn + 18) sl_st <= SL_WAIT;
                end
                default: ;
            endcase
        end
    end

    // Slave drives: start bit after sl_turn silent cycles, 16 data bits, then one trailing 0.
    always_comb begin
        sl_oe  = 1'b0;
        sl_val = 1'b1;
        if (sl_st == SL_RD && !sl_silent) begin
            if (sl_ph == sl_turn + 1) begin
                sl_oe = 1'b1; sl_val = 1'b0;
            end else if (sl_ph >= sl_turn + 2 && sl_ph <= sl_turn + 17) begin
                sl_oe = 1'b1; sl_val = sl_rd_data[sl_ph - sl_turn - 2];
            end else if (sl_ph == sl_turn + 18) begin
                sl_oe = 1'b1; sl_val = 1'b0;
            end
        end
    end

    assign SDA = sl_oe ? sl_val : 1'bz;

    // Bus level expected in read-frame phase ph (ph=1 is the first TURN cycle) with the master released.
    function automatic logic exp_bus(input int ph, input int turn, input bit silent, input logic [15:0] v);
        if (silent) return 1'b1;
        if (ph == turn + 1) return 1'b0;
        if (ph >= turn + 2 && ph <= turn + 17) return v[ph - turn - 2];
        if (ph == turn + 18) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [15:0] d;
        int          turn;
        bit          silent;
        logic [15:0] rdv;
        int          lat;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic run_txn(input string tag, input vec_t v);
        int c0, k, rc, npulse, bad_bus, bad_scl;
        logic [25:0] bits;
        logic [15:0] got_rd;
        logic        got_err;
        sl_turn = v.turn; sl_silent = v.silent; sl_rd_data = v.rdv;
        @(negedge clk);
        chk({tag, " ready"}, cmd_ready, 1'b1);
        chk({tag, " rdata held"}, rsp_rdata, last_rd);
        chk({tag, " err held"}, rsp_err, last_err);
        cmd_valid = 1'b1; cmd_write = v.w; cmd_addr = v.a; cmd_wdata = v.d;
        c0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 1; rc = -1; npulse = 0; bad_bus = 0; bad_scl = 0;
        bits = '0; got_rd = 16'h0000; got_err = 1'b0;
        while (!cmd_ready && k < 200) begin
            if (SCL !== 1'b0 || busy !== 1'b1) bad_scl++;
            if (v.w && k <= 26) bits[k-1] = SDA;
            if (!v.w && k >= 11 && SDA !== exp_bus(k - 10, v.turn, v.silent, v.rdv)) bad_bus++;
            if (rsp_valid) begin
                npulse++;
                if (rc < 0) begin rc = k; got_rd = rsp_rdata; got_err = rsp_err; end
            end
            @(negedge clk);
            k++;
        end
        chk({tag, " completed"}, cmd_ready, 1'b1);
        chk({tag, " latency"}, rc, v.lat);
        chk({tag, " rsp_rdata"}, got_rd, v.exp_rd);
        chk({tag, " rsp_err"}, got_err, v.exp_err);
        chk({tag, " rsp pulses"}, npulse, 1);
        chk({tag, " gap length"}, k - rc, IDLE_GAP);
        chk({tag, " SCL/busy in frame"}, bad_scl, 0);
        chk({tag, " idle SCL"}, SCL, 1'b1);
        chk({tag, " idle busy"}, busy, 1'b0);
        chk({tag, " idle SDA"}, SDA, 1'b1);
        chk({tag, " rdata after"}, rsp_rdata, v.exp_rd);
        if (v.w) begin
            chk({tag, " SDA frame"}, bits, {v.d, v.a, v.w, 1'b0});
            chk({tag, " slave reg"}, sl_mem[v.a], v.d);
        end else begin
            chk({tag, " bus released"}, bad_bus, 0);
            chk({tag, " slave addr"}, sl_last_addr, v.a);
        end
        last_rd = v.exp_rd; last_err = v.exp_err;
    endtask

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc [2];
        int rsp_c [2];
        logic [15:0] rd [2];
        logic er [2];
        int na, nr, c0, bad;
        bit sw, drop;
        logic [15:0] cafe;

        vecs[0] = '{1'b1, 8'h3C, 16'hBEEF, 0,  1'b0, 16'h0000, 27, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 8'h3C, 16'h0000, 3,  1'b0, 16'hA5C3, 31, 16'hA5C3, 1'b0};
        vecs[2] = '{1'b0, 8'h3C, 16'h0000, 0,  1'b1, 16'h0000, 27, 16'h0000, 1'b1};
        vecs[3] = '{1'b0, 8'h81, 16'h0000, 0,  1'b0, 16'h0001, 28, 16'h0001, 1'b0};
        vecs[4] = '{1'b0, 8'hFF, 16'h0000, 15, 1'b0, 16'h8000, 43, 16'h8000, 1'b0};
        vecs[5] = '{1'b1, 8'h00, 16'hFFFF, 0,  1'b0, 16'h0000, 27, 16'h0000, 1'b0};
        vecs[6] = '{1'b1, 8'hA5, 16'h0000, 0,  1'b0, 16'h0000, 27, 16'h0000, 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        chk("reset cmd_ready", cmd_ready, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset SCL", SCL, 1'b1);
        chk("reset SDA", SDA, 1'b1);
        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset rsp_rdata", rsp_rdata, 16'h0000);
        chk("reset rsp_err", rsp_err, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // back-to-back: write then read with cmd_valid held high throughout
        sl_turn = 2; sl_silent = 1'b0; sl_rd_data = 16'h5A5A;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h12; cmd_wdata = 16'h1234;
        na = 0; nr = 0; sw = 1'b0; drop = 1'b0;
        acc[0] = 0; acc[1] = 0; rsp_c[0] = 0; rsp_c[1] = 0;
        rd[0] = 16'h0000; rd[1] = 16'h0000; er[0] = 1'b0; er[1] = 1'b0;
        for (int i = 0; i < 200 && nr < 2; i++) begin
            if (sw) begin cmd_write = 1'b0; cmd_wdata = 16'hFFFF; sw = 1'b0; end
            if (drop) begin cmd_valid = 1'b0; drop = 1'b0; end
            if (cmd_valid && cmd_ready) begin
                if (na < 2) acc[na] = cyc;
                na++;
                if (na == 1) sw = 1'b1; else drop = 1'b1;
            end
            if (rsp_valid) begin
                if (nr < 2) begin rsp_c[nr] = cyc; rd[nr] = rsp_rdata; er[nr] = rsp_err; end
                nr++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (10) begin
            if (rsp_valid) nr++;
            @(negedge clk);
        end
        chk("b2b acceptances", na, 2);
        chk("b2b responses", nr, 2);
        chk("b2b write latency", rsp_c[0] - acc[0], 27);
        chk("b2b second acceptance", acc[1] - rsp_c[0], IDLE_GAP);
        chk("b2b read latency", rsp_c[1] - acc[1], 30);
        chk("b2b write rdata", rd[0], 16'h0000);
        chk("b2b read rdata", rd[1], 16'h5A5A);
        chk("b2b read err", er[1], 1'b0);
        chk("b2b slave reg", sl_mem[8'h12], 16'h1234);
        last_rd = 16'h5A5A; last_err = 1'b0;

        // reset in the middle of a write frame
        run_txn("pre write", '{1'b1, 8'h77, 16'h1111, 0, 1'b0, 16'h0000, 27, 16'h0000, 1'b0});
        run_txn("pre read", '{1'b0, 8'h77, 16'h0000, 1, 1'b0, 16'h7E57, 29, 16'h7E57, 1'b0});
        sl_turn = 0; sl_silent = 1'b0;
        cafe = 16'hCAFE;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h77; cmd_wdata = cafe;
        c0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (cyc < c0 + 22) @(negedge clk);
        chk("rst wdata bit11", SDA, cafe[11]);
        chk("rst busy before", busy, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst async cmd_ready", cmd_ready, 1'b1);
        chk("rst async busy", busy, 1'b0);
        chk("rst async SCL", SCL, 1'b1);
        chk("rst async SDA", SDA, 1'b1);
        chk("rst async rsp_valid", rsp_valid, 1'b0);
        chk("rst async rsp_rdata", rsp_rdata, 16'h0000);
        chk("rst async rsp_err", rsp_err, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid || !cmd_ready) bad++;
        end
        chk("rst no response", bad, 0);
        chk("rst aborted write", sl_mem[8'h77], 16'h1111);
        last_rd = 16'h0000; last_err = 1'b0;
        run_txn("post write", '{1'b1, 8'h77, 16'h2222, 0, 1'b0, 16'h0000, 27, 16'h0000, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
